actuator_scheduler: RTL and testbench

// - Shares one actuator (element-wise nonlinearity of the integer ESN) among NUM_REQ requesters.
// - Each requester is a reservoir-update lane or the readout path.
// - Grants round-robin, launches the actuator with a one-cycle enable pulse and waits for its completion.
// - Returns the actuator result to the granted requester, with a watchdog against a stalled actuator.

---
 rtl/actuator_scheduler_pkg.sv | 21 ++
 rtl/actuator_scheduler_rr_arbiter.sv | 31 +++
 rtl/actuator_scheduler.sv | 155 +++++++++++++++
 tb/tb_actuator_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/actuator_scheduler_pkg.sv
// Shared definitions for the ESN actuator scheduler: FSM state encoding and a
// constant clog2 helper used to size the pointer and watchdog timer.
package actuator_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/actuator_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set request bit at or above the
// pointer, wrapping around. The pointer register itself lives in the caller.
module rr_arbiter
  import actuator_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [PTR_W-1:0] cand_idx;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand_idx]) begin
        grant_idx   = cand_idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/actuator_scheduler.sv
// Shares one ESN nonlinearity actuator among NUM_REQ requesters: round-robin
// grant, one-cycle launch pulse, bounded wait for completion, registered reply.
module actuator_scheduler
  import actuator_scheduler_pkg::*;
#(
  parameter int weight_size = 5,
  parameter int demention   = 10,
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                           iClk,
  input  logic                           iRst,
  input  logic [NUM_REQ-1:0]             iReq,
  input  logic [NUM_REQ*demention-1:0]   iReqData,
  output logic [NUM_REQ-1:0]             oAck,
  output logic                           oRspValid,
  output logic [demention-1:0]           oRspData,
  output logic                           oTimeout,
  output logic                           oBusy,
  output logic                           oActEn,
  output logic [demention-1:0]           oActData,
  input  logic [demention-1:0]           iActData,
  input  logic                           iActComplete
);

  localparam int PTR_W   = clog2(NUM_REQ);
  localparam int TIMER_W = clog2(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(NUM_REQ - 1);

  // weight_size only keeps the parameter list aligned with the actuator.
  if (weight_size < 1) begin : g_weight_size_unused
  end

  logic [demention-1:0] req_words [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_words[gi] = iReqData[gi*demention +: demention];
  end

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     grant_q, grant_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [TIMER_W-1:0]   timer_inc;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [demention-1:0] rsp_data_q, rsp_data_d;
  logic                 timeout_q, timeout_d;
  logic                 busy_q, busy_d;
  logic                 act_en_q, act_en_d;
  logic [demention-1:0] act_data_q, act_data_d;

  logic [PTR_W-1:0]     arb_idx;
  logic                 arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req         (iReq),
    .ptr         (ptr_q),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    timer_d     = timer_q;
    ack_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    timeout_d   = 1'b0;
    act_en_d    = 1'b0;
    act_data_d  = act_data_q;
    timer_inc   = timer_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          grant_d    = arb_idx;
          act_data_d = req_words[arb_idx];
          act_en_d   = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The incremented count is compared so the abort reply lands exactly
        // TIMEOUT cycles after the launch pulse; completion takes priority.
        timer_d = timer_inc;
        if (iActComplete) begin
          ack_d[grant_q] = 1'b1;
          rsp_valid_d    = 1'b1;
          rsp_data_d     = iActData;
          state_d        = S_RESP;
        end else if (timer_inc == TIMER_LAST) begin
          ack_d[grant_q] = 1'b1;
          rsp_valid_d    = 1'b1;
          timeout_d      = 1'b1;
          state_d        = S_RESP;
        end
      end
      S_RESP: begin
        ptr_d   = (grant_q == PTR_LAST) ? '0 : grant_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      timer_q     <= '0;
      ack_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      act_en_q    <= 1'b0;
      act_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      timer_q     <= timer_d;
      ack_q       <= ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      act_en_q    <= act_en_d;
      act_data_q  <= act_data_d;
    end
  end

  assign oAck      = ack_q;
  assign oRspValid = rsp_valid_q;
  assign oRspData  = rsp_data_q;
  assign oTimeout  = timeout_q;
  assign oBusy     = busy_q;
  assign oActEn    = act_en_q;
  assign oActData  = act_data_q;

endmodule

// File: tb/tb_actuator_scheduler.sv
// Randomised and directed bench for actuator_scheduler against a cycle-count
// reference model; the actuator model echoes ~operand after a delay D.
module tb_actuator_scheduler;

  localparam int NR = 4;
  localparam int DW = 10;
  localparam int TO = 64;

  logic              clk;
  logic              iRst;
  logic [NR-1:0]     iReq;
  logic [NR*DW-1:0]  iReqData;
  logic [NR-1:0]     oAck;
  logic              oRspValid;
  logic [DW-1:0]     oRspData;
  logic              oTimeout;
  logic              oBusy;
  logic              oActEn;
  logic [DW-1:0]     oActData;
  logic [DW-1:0]     iActData;
  logic              iActComplete;

  actuator_scheduler #(
    .weight_size (5),
    .demention   (DW),
    .NUM_REQ     (NR),
    .TIMEOUT     (TO)
  ) dut (
    .iClk         (clk),
    .iRst         (iRst),
    .iReq         (iReq),
    .iReqData     (iReqData),
    .oAck         (oAck),
    .oRspValid    (oRspValid),
    .oRspData     (oRspData),
    .oTimeout     (oTimeout),
    .oBusy        (oBusy),
    .oActEn       (oActEn),
    .oActData     (oActData),
    .iActData     (iActData),
    .iActComplete (iActComplete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc_now = 0;
  int en_count = 0;
  int en_cyc = -1;
  int proto_bad = 0;
  logic [DW-1:0] en_op;
  logic [NR-1:0] s_ack;
  logic          s_valid, s_to, s_en;
  logic [DW-1:0] s_data, s_actdata;

  int act_delay = 1;
  bit act_never = 0;
  bit force_hi = 0;
  bit drop_next = 0;
  int act_cnt = 0;
  logic [DW-1:0] act_op = '0;

  logic [DW-1:0] req_data [NR];
  int model_ptr = 0;

  function automatic int model_grant(input logic [NR-1:0] mask, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int idx);
    logic [NR-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  task automatic set_data(input int r, input logic [DW-1:0] v);
    req_data[r] = v;
    iReqData[r*DW +: DW] = v;
  endtask

  // One clock: sample DUT, then drive the actuator model for the next edge.
  task automatic tick();
    bit fire;
    @(posedge clk);
    #1;
    cyc_now++;
    s_ack = oAck; s_valid = oRspValid; s_data = oRspData; s_to = oTimeout;
    s_en = oActEn; s_actdata = oActData;
    if (s_en) begin en_count++; en_cyc = cyc_now; en_op = s_actdata; end
    if ($countones(s_ack) > 1 || s_valid != (s_ack != '0) || (s_to && !s_valid))
      proto_bad++;
    if (s_ack != '0)
      $display("[%0d] txn ack=%b data=%h timeout=%b", cyc_now, s_ack, s_data, s_to);
    if (drop_next) begin force_hi = 0; drop_next = 0; end
    if (s_en && force_hi) drop_next = 1;
    fire = 0;
    if (act_cnt > 0) begin act_cnt--; fire = (act_cnt == 0); end
    if (s_en && !act_never) act_cnt = act_delay;
    if (s_en) act_op = s_actdata;
    if (fire) begin iActComplete = 1'b1; iActData = ~act_op; end
    else if (force_hi) begin iActComplete = 1'b1; iActData = 10'h2AA; end
    else begin iActComplete = 1'b0; iActData = DW'($urandom); end
  endtask

  task automatic wait_ack(input int budget, output bit got, output int ack_cyc);
    got = 0;
    ack_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (s_ack != '0) begin got = 1; ack_cyc = cyc_now; return; end
    end
  endtask

  task automatic test_reset();
    logic [27:0] outs;
    iRst = 1'b0; iReq = '0; iReqData = '0; iActData = '0; iActComplete = 1'b0;
    for (int r = 0; r < NR; r++) req_data[r] = '0;
    #2 iRst = 1'b1;
    #1;
    outs = {oAck, oRspValid, oRspData, oTimeout, oBusy, oActEn, oActData};
    compared++;
    if (outs !== '0) begin mismatched++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    tick(); tick();
    iRst = 1'b0;
    tick(); tick();
    outs = {oAck, oRspValid, oRspData, oTimeout, oBusy, oActEn, oActData};
    compared++;
    if (outs !== '0) begin mismatched++; $display("FAIL idle_after_reset: got %h expected 0", outs); end
    model_ptr = 0;
  endtask

  task automatic test_single();
    bit got; int ac; int t0; int en0;
    act_delay = 3;
    set_data(1, 10'b1000001000);
    en0 = en_count;
    iReq = 4'b0010;
    t0 = cyc_now;
    wait_ack(20, got, ac);
    iReq = '0;
    compared++;
    if (got !== 1'b1) begin mismatched++; $display("FAIL single_ack_seen: got %0d expected 1", got); end
    compared++;
    if (s_ack !== 4'b0010) begin mismatched++; $display("FAIL single_ack: got %b expected 0010", s_ack); end
    compared++;
    if (s_data !== 10'b0111110111) begin mismatched++; $display("FAIL single_data: got %b expected 0111110111", s_data); end
    compared++;
    if (s_to !== 1'b0) begin mismatched++; $display("FAIL single_timeout: got %b expected 0", s_to); end
    compared++;
    if (ac - t0 != 5) begin mismatched++; $display("FAIL single_latency: got %0d expected 5", ac - t0); end
    compared++;
    if (en_cyc - t0 != 1 || en_op !== 10'b1000001000) begin
      mismatched++; $display("FAIL single_issue: got cyc %0d op %b expected cyc 1 op 1000001000", en_cyc - t0, en_op);
    end
    for (int i = 0; i < 4; i++) tick();
    compared++;
    if (en_count - en0 != 1) begin mismatched++; $display("FAIL single_en_pulses: got %0d expected 1", en_count - en0); end
    compared++;
    if (oBusy !== 1'b0) begin mismatched++; $display("FAIL single_busy_idle: got %b expected 0", oBusy); end
    model_ptr = 2;
  endtask

  task automatic test_round_robin();
    bit got; int ac; int prev; int exp;
    act_delay = 1;
    proto_bad = 0;
    for (int r = 0; r < NR; r++) set_data(r, DW'($urandom));
    iReq = 4'hF;
    prev = -1;
    for (int n = 0; n < 8; n++) begin
      wait_ack(20, got, ac);
      exp = model_grant(4'hF, model_ptr);
      compared++;
      if (s_ack !== onehot(exp) || s_data !== ~req_data[exp]) begin
        mismatched++; $display("FAIL rr_grant_%0d: got ack %b data %h expected ack %b data %h", n, s_ack, s_data, onehot(exp), ~req_data[exp]);
      end
      if (n > 0) begin
        compared++;
        if (ac - prev != 4) begin mismatched++; $display("FAIL rr_period_%0d: got %0d expected 4", n, ac - prev); end
      end
      model_ptr = (exp + 1) % NR;
      prev = ac;
      set_data(exp, DW'($urandom));
    end
    iReq = '0;
    compared++;
    if (proto_bad != 0) begin mismatched++; $display("FAIL rr_protocol: got %0d violations expected 0", proto_bad); end
    tick();
  endtask

  task automatic test_timeout();
    bit got; int ac; int exp; logic [NR-1:0] mask; int delays [2];
    act_never = 1;
    set_data(0, DW'($urandom)); set_data(3, DW'($urandom));
    mask = 4'b1001;
    iReq = mask;
    wait_ack(100, got, ac);
    exp = model_grant(mask, model_ptr);
    compared++;
    if (got !== 1'b1 || s_ack !== onehot(exp) || s_to !== 1'b1 || s_data !== '0) begin
      mismatched++; $display("FAIL timeout_resp: got ack %b to %b data %h expected ack %b to 1 data 0", s_ack, s_to, s_data, onehot(exp));
    end
    compared++;
    if (ac - en_cyc != TO) begin mismatched++; $display("FAIL timeout_latency: got %0d expected %0d", ac - en_cyc, TO); end
    model_ptr = (exp + 1) % NR;
    mask[exp] = 1'b0;
    iReq = mask;
    act_never = 0;
    act_delay = 2;
    wait_ack(20, got, ac);
    exp = model_grant(mask, model_ptr);
    iReq = '0;
    compared++;
    if (s_ack !== onehot(exp) || s_to !== 1'b0 || s_data !== ~req_data[exp] || ac - en_cyc != 3) begin
      mismatched++; $display("FAIL after_timeout: got ack %b to %b data %h lat %0d expected ack %b to 0 data %h lat 3",
                             s_ack, s_to, s_data, ac - en_cyc, onehot(exp), ~req_data[exp]);
    end
    model_ptr = (exp + 1) % NR;
    tick();
    delays[0] = TO - 1; delays[1] = TO - 2;
    foreach (delays[i]) begin
      act_delay = delays[i];
      set_data(2, DW'($urandom));
      iReq = 4'b0100;
      wait_ack(100, got, ac);
      iReq = '0;
      compared++;
      if (s_to !== 1'b0 || s_data !== ~req_data[2] || ac - en_cyc != delays[i] + 1) begin
        mismatched++; $display("FAIL late_complete_d%0d: got to %b data %h lat %0d expected to 0 data %h lat %0d",
                               delays[i], s_to, s_data, ac - en_cyc, ~req_data[2], delays[i] + 1);
      end
      model_ptr = 3;
      tick();
    end
  endtask

  task automatic test_complete_held();
    bit got; int ac; int t0; int extra;
    force_hi = 1;
    tick(); tick();
    act_delay = 5;
    set_data(0, DW'($urandom));
    iReq = 4'b0001;
    t0 = cyc_now;
    wait_ack(30, got, ac);
    iReq = '0;
    compared++;
    if (got !== 1'b1 || ac - t0 != 7 || s_data !== ~req_data[0] || s_to !== 1'b0) begin
      mismatched++; $display("FAIL held_complete: got lat %0d data %h to %b expected lat 7 data %h to 0", ac - t0, s_data, s_to, ~req_data[0]);
    end
    model_ptr = 1;
    extra = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (s_ack != '0) extra++; end
    compared++;
    if (extra != 0) begin mismatched++; $display("FAIL held_single_ack: got %0d extra acks expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    bit got; int ac; int acks; logic [27:0] outs;
    act_delay = 2;
    set_data(2, DW'($urandom));
    iReq = 4'b0100;
    wait_ack(20, got, ac);
    iReq = '0;
    tick();
    act_never = 1;
    iReq = 4'b0100;
    for (int i = 0; i < 10 && !s_en; i++) tick();
    compared++;
    if (s_en !== 1'b1) begin mismatched++; $display("FAIL midrst_issue_seen: got %b expected 1", s_en); end
    tick(); tick(); tick();
    #2 iRst = 1'b1;
    #1;
    outs = {oAck, oRspValid, oRspData, oTimeout, oBusy, oActEn, oActData};
    compared++;
    if (outs !== '0) begin mismatched++; $display("FAIL midrst_outputs: got %h expected 0", outs); end
    iReq = '0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (s_ack != '0 || oBusy) acks++; end
    compared++;
    if (acks != 0) begin mismatched++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", acks); end
    iRst = 1'b0;
    act_never = 0; act_cnt = 0; act_delay = 2;
    model_ptr = 0;
    set_data(1, DW'($urandom)); set_data(3, DW'($urandom));
    iReq = 4'b1010;
    wait_ack(20, got, ac);
    iReq = '0;
    compared++;
    if (s_ack !== onehot(model_grant(4'b1010, model_ptr))) begin
      mismatched++; $display("FAIL midrst_first_grant: got %b expected %b", s_ack, onehot(model_grant(4'b1010, model_ptr)));
    end
    model_ptr = 2;
    tick();
  endtask

  task automatic test_drop();
    bit got; int ac;
    act_delay = 4;
    set_data(2, DW'($urandom));
    iReq = 4'b0100;
    for (int i = 0; i < 10 && !s_en; i++) tick();
    tick();
    iReq = '0;
    wait_ack(20, got, ac);
    compared++;
    if (got !== 1'b1 || s_ack !== 4'b0100 || s_data !== ~req_data[2]) begin
      mismatched++; $display("FAIL drop_ack: got ack %b data %h expected ack 0100 data %h", s_ack, s_data, ~req_data[2]);
    end
    model_ptr = 3;
    set_data(0, DW'($urandom)); set_data(3, DW'($urandom));
    iReq = 4'b1001;
    wait_ack(20, got, ac);
    iReq = '0;
    compared++;
    if (s_ack !== onehot(model_grant(4'b1001, model_ptr))) begin
      mismatched++; $display("FAIL drop_ptr_advance: got %b expected %b", s_ack, onehot(model_grant(4'b1001, model_ptr)));
    end
    model_ptr = 0;
    tick();
  endtask

  task automatic test_random();
    bit got; int ac; int exp; logic [NR-1:0] pend; logic [NR-1:0] add;
    proto_bad = 0;
    pend = '0;
    for (int n = 0; n < 40; n++) begin
      add = NR'($urandom_range(0, 15)) & ~pend;
      if ((pend | add) == '0) add = onehot($urandom_range(0, NR - 1));
      for (int r = 0; r < NR; r++) if (add[r]) set_data(r, DW'($urandom));
      pend = pend | add;
      act_delay = $urandom_range(1, 6);
      iReq = pend;
      wait_ack(20, got, ac);
      exp = model_grant(pend, model_ptr);
      compared++;
      if (got !== 1'b1 || s_ack !== onehot(exp) || s_data !== ~req_data[exp] || s_to !== 1'b0 || ac - en_cyc != act_delay + 1) begin
        mismatched++; $display("FAIL rand_%0d: got ack %b data %h to %b lat %0d expected ack %b data %h to 0 lat %0d",
                               n, s_ack, s_data, s_to, ac - en_cyc, onehot(exp), ~req_data[exp], act_delay + 1);
      end
      if (exp >= 0) pend[exp] = 1'b0;
      model_ptr = (exp + 1) % NR;
      iReq = pend;
    end
    iReq = '0;
    tick();
    compared++;
    if (proto_bad != 0) begin mismatched++; $display("FAIL rand_protocol: got %0d violations expected 0", proto_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_complete_held();
    test_reset_mid();
    test_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
